// File: rtl/multi_port_fwft_fifo_pkg.sv
// Shared helpers for the multi-port FWFT FIFO: bit-counting functions,
// the default count type and a configuration sanity check.
package multi_port_fwft_fifo_pkg;

  localparam int MPF_ADDR_WIDTH = 4;

  // Occupancy / free-space type for the default depth (ADDR_WIDTH+1 bits).
  typedef logic [MPF_ADDR_WIDTH:0] mpf_count_t;

  // Number of set bits in v.
  function automatic int unsigned popcount(input logic [63:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < 64; i++) c += 32'(v[i]);
    return c;
  endfunction

  // Number of consecutive ones in v starting at bit 0, looking at n bits.
  function automatic int unsigned leading_ones(input logic [63:0] v,
                                               input int unsigned n);
    int unsigned c;
    bit          stop;
    c    = 0;
    stop = 1'b0;
    for (int unsigned i = 0; i < 64; i++) begin
      if (i < n && !stop) begin
        if (v[i]) c++;
        else      stop = 1'b1;
      end
    end
    return c;
  endfunction

  // Port counts must fit the depth and thresholds must lie below it.
  function automatic bit cfg_ok(input int aw, input int nwp, input int nrp,
                                input int aft, input int aet);
    int depth;
    depth = 1 << aw;
    return (nwp >= 1) && (nwp <= depth) && (nrp >= 1) && (nrp <= depth) &&
           (nwp <= 64) && (nrp <= 64) && (aft < depth) && (aet < depth);
  endfunction

endpackage

// File: rtl/multi_port_fwft_fifo_write_compactor.sv
// mpf_write_compactor: per-lane write grant from free space, plus the
// compacted slot offset of every accepted lane and the total write count.
module mpf_write_compactor
  import multi_port_fwft_fifo_pkg::*;
#(
  parameter int NUM_WRITE_PORTS = 2,
  parameter int ADDR_WIDTH      = 4
) (
  input  logic [NUM_WRITE_PORTS-1:0]                 wr_valid_i,
  input  logic [ADDR_WIDTH:0]                        free_count_i,
  output logic [NUM_WRITE_PORTS-1:0]                 wr_ready_o,
  output logic [NUM_WRITE_PORTS-1:0]                 accept_o,
  output logic [NUM_WRITE_PORTS-1:0][ADDR_WIDTH-1:0] rank_o,
  output logic [ADDR_WIDTH:0]                        wr_cnt_o
);

  // Lane i is granted when at least i+1 slots are free; valid never feeds ready.
  for (genvar i = 0; i < NUM_WRITE_PORTS; i++) begin : g_lane
    assign wr_ready_o[i] = (free_count_i > (ADDR_WIDTH+1)'(i));
  end

  assign accept_o = wr_valid_i & wr_ready_o;
  assign wr_cnt_o = (ADDR_WIDTH+1)'(popcount(64'(accept_o)));

  // Running count of lower accepted lanes gives each lane its packed offset.
  always_comb begin
    logic [ADDR_WIDTH-1:0] run;
    run    = '0;
    rank_o = '0;
    for (int i = 0; i < NUM_WRITE_PORTS; i++) begin
      rank_o[i] = run;
      run       = run + ADDR_WIDTH'(accept_o[i]);
    end
  end

endmodule

// File: rtl/multi_port_fwft_fifo.sv
// multi_port_fwft_fifo: N-write / M-read synchronous FIFO with FWFT read slots,
// compacted sparse writes, prefix pops and synchronous flush.
// Optional sticky overflow/underflow flags: MULTI_PORT_FWFT_FIFO_ERR_EN.
module multi_port_fwft_fifo
  import multi_port_fwft_fifo_pkg::*;
#(
  parameter int DATA_WIDTH             = 32,
  parameter int ADDR_WIDTH             = 4,
  parameter int NUM_WRITE_PORTS        = 2,
  parameter int NUM_READ_PORTS         = 2,
  parameter int ALMOST_FULL_THRESHOLD  = 2,
  parameter int ALMOST_EMPTY_THRESHOLD = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 flush,
  input  logic [NUM_WRITE_PORTS-1:0]           wr_valid,
  input  logic [NUM_WRITE_PORTS*DATA_WIDTH-1:0] wr_data,
  output logic [NUM_WRITE_PORTS-1:0]           wr_ready,
  output logic [NUM_READ_PORTS-1:0]            rd_valid,
  output logic [NUM_READ_PORTS*DATA_WIDTH-1:0] rd_data,
  input  logic [NUM_READ_PORTS-1:0]            rd_ready,
  output logic [ADDR_WIDTH:0]                  data_count,
  output logic [ADDR_WIDTH:0]                  free_count,
  output logic                                 full,
  output logic                                 empty,
  output logic                                 almost_full,
  output logic                                 almost_empty,
  output logic                                 ovf_err,
  output logic                                 udf_err
);

  localparam int                 DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

  if (!cfg_ok(ADDR_WIDTH, NUM_WRITE_PORTS, NUM_READ_PORTS,
              ALMOST_FULL_THRESHOLD, ALMOST_EMPTY_THRESHOLD)) begin : g_bad_cfg
    $error("multi_port_fwft_fifo: port count or threshold exceeds depth");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, cnt_q, cnt_d;
  logic [ADDR_WIDTH:0]   wr_cnt, pops;
  logic [NUM_WRITE_PORTS-1:0]                 accept;
  logic [NUM_WRITE_PORTS-1:0][ADDR_WIDTH-1:0] rank;
  logic [NUM_WRITE_PORTS-1:0][ADDR_WIDTH-1:0] waddr;

  assign free_count = DEPTH_C - cnt_q;
  assign data_count = cnt_q;

  mpf_write_compactor #(
    .NUM_WRITE_PORTS (NUM_WRITE_PORTS),
    .ADDR_WIDTH      (ADDR_WIDTH)
  ) u_compactor (
    .wr_valid_i   (wr_valid),
    .free_count_i (free_count),
    .wr_ready_o   (wr_ready),
    .accept_o     (accept),
    .rank_o       (rank),
    .wr_cnt_o     (wr_cnt)
  );

  for (genvar i = 0; i < NUM_WRITE_PORTS; i++) begin : g_waddr
    assign waddr[i] = wr_ptr_q[ADDR_WIDTH-1:0] + rank[i];
  end

  // Store accepted lanes into consecutive slots; flush/reset discard them.
  always_ff @(posedge clk) begin
    if (rst_n && !flush) begin
      for (int i = 0; i < NUM_WRITE_PORTS; i++)
        if (accept[i]) mem_q[waddr[i]] <= wr_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // FWFT read slots: slot k shows the k-th oldest entry.
  for (genvar k = 0; k < NUM_READ_PORTS; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] raddr;
    assign raddr    = rd_ptr_q[ADDR_WIDTH-1:0] + ADDR_WIDTH'(k);
    assign rd_valid[k] = (cnt_q > (ADDR_WIDTH+1)'(k));
    assign rd_data[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[raddr];
  end

  // Only an unbroken run of taken slots from slot 0 is consumed.
  assign pops = (ADDR_WIDTH+1)'(leading_ones(64'(rd_valid & rd_ready),
                                             NUM_READ_PORTS));

  // Next pointer/count; flush wins over any same-cycle handshakes.
  always_comb begin
    wr_ptr_d = wr_ptr_q + wr_cnt;
    rd_ptr_d = rd_ptr_q + pops;
    cnt_d    = cnt_q + wr_cnt - pops;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign full         = (cnt_q == DEPTH_C);
  assign empty        = (cnt_q == '0);
  assign almost_full  = (free_count <= (ADDR_WIDTH+1)'(ALMOST_FULL_THRESHOLD));
  assign almost_empty = (cnt_q <= (ADDR_WIDTH+1)'(ALMOST_EMPTY_THRESHOLD));

`ifdef MULTI_PORT_FWFT_FIFO_ERR_EN
  logic ovf_q, udf_q;

  // Sticky protocol errors, cleared only by reset (flush leaves them alone).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (|(wr_valid & ~wr_ready)) ovf_q <= 1'b1;
      if (|(rd_ready & ~rd_valid)) udf_q <= 1'b1;
    end
  end

  assign ovf_err = ovf_q;
  assign udf_err = udf_q;
`else
  assign ovf_err = 1'b0;
  assign udf_err = 1'b0;
`endif

endmodule

// File: tb/tb_multi_port_fwft_fifo.sv
// Self-checking bench for multi_port_fwft_fifo (depth 16, 2W/2R) against a
// queue-based reference model.
module tb_multi_port_fwft_fifo;

`ifdef MULTI_PORT_FWFT_FIFO_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  localparam int DEPTH = 16;

  logic        clk, rst_n, flush;
  logic [1:0]  wr_valid, wr_ready, rd_valid, rd_ready;
  logic [63:0] wr_data, rd_data;
  logic [4:0]  data_count, free_count;
  logic        full, empty, almost_full, almost_empty, ovf_err, udf_err;

  int nvec = 0;
  int nerr = 0;

  logic [31:0] mq[$];
  bit          m_ovf, m_udf;

  multi_port_fwft_fifo dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
    .data_count(data_count), .free_count(free_count),
    .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .ovf_err(ovf_err), .udf_err(udf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance the reference model by one clock using the current inputs,
  // then let the DUT take the same edge and settle.
  task automatic tick();
    int sz, pops, free;
    bit stop;
    logic [31:0] acc[$];
    sz = mq.size(); free = DEPTH - sz; pops = 0; stop = 0;
    if (!rst_n) begin
      mq.delete(); m_ovf = 0; m_udf = 0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (wr_valid[i] && free > i) acc.push_back(wr_data[i*32 +: 32]);
        if (wr_valid[i] && !(free > i) && ERR_EN) m_ovf = 1;
      end
      for (int k = 0; k < 2; k++) begin
        if (rd_ready[k] && !(sz > k) && ERR_EN) m_udf = 1;
        if (!stop && rd_ready[k] && sz > k) pops++;
        else stop = 1;
      end
      if (flush) mq.delete();
      else begin
        repeat (pops) void'(mq.pop_front());
        foreach (acc[j]) mq.push_back(acc[j]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    rst_n = 1; flush = 0; wr_valid = 0; rd_ready = 0; wr_data = '0;
  endtask

  task automatic test_reset();
    idle(); rst_n = 0; wr_valid = 2'b11; rd_ready = 2'b11;
    tick(); tick(); idle();
    nvec++; if (rd_valid !== 2'b00) begin nerr++; $display("FAIL reset_rd_valid got %b exp 00", rd_valid); end
    nvec++; if (wr_ready !== 2'b11) begin nerr++; $display("FAIL reset_wr_ready got %b exp 11", wr_ready); end
    nvec++; if (empty !== 1'b1 || almost_empty !== 1'b1 || full !== 1'b0) begin nerr++; $display("FAIL reset_flags got e=%b ae=%b f=%b exp 1 1 0", empty, almost_empty, full); end
    nvec++; if (free_count !== 5'd16 || data_count !== 5'd0) begin nerr++; $display("FAIL reset_counts got free=%0d cnt=%0d exp 16 0", free_count, data_count); end
    nvec++; if (ovf_err !== 1'b0 || udf_err !== 1'b0) begin nerr++; $display("FAIL reset_err got %b%b exp 00", ovf_err, udf_err); end
  endtask

  task automatic test_fill();
    for (int c = 0; c < 8; c++) begin
      wr_valid = 2'b11; wr_data = {32'(2*c+1), 32'(2*c)}; tick();
    end
    idle();
    nvec++; if (data_count !== 5'd16 || full !== 1'b1) begin nerr++; $display("FAIL fill_count got cnt=%0d full=%b exp 16 1", data_count, full); end
    nvec++; if (wr_ready !== 2'b00 || almost_full !== 1'b1) begin nerr++; $display("FAIL fill_ready got %b af=%b exp 00 1", wr_ready, almost_full); end
    nvec++; if (rd_data[31:0] !== 32'd0 || rd_data[63:32] !== 32'd1) begin nerr++; $display("FAIL fill_slots got %0d %0d exp 0 1", rd_data[31:0], rd_data[63:32]); end
    nvec++; if (mq.size() != 16 || mq[15] !== 32'd15) begin nerr++; $display("FAIL fill_model got size %0d exp 16", mq.size()); end
  endtask

  task automatic test_sparse();
    flush = 1; tick(); idle();
    wr_valid = 2'b10; wr_data = {32'hA5, 32'hDEAD}; tick(); idle();
    nvec++; if (rd_valid !== 2'b01) begin nerr++; $display("FAIL sparse_valid got %b exp 01", rd_valid); end
    nvec++; if (rd_data[31:0] !== 32'hA5) begin nerr++; $display("FAIL sparse_data got %h exp a5", rd_data[31:0]); end
    nvec++; if (data_count !== 5'd1) begin nerr++; $display("FAIL sparse_count got %0d exp 1", data_count); end
  endtask

  task automatic test_overflow();
    rst_n = 0; tick(); idle();
    for (int c = 0; c < 7; c++) begin wr_valid = 2'b11; wr_data = {32'(2*c+1), 32'(2*c)}; tick(); end
    wr_valid = 2'b01; wr_data = {32'hFFFF, 32'd14}; tick(); idle();
    nvec++; if (wr_ready !== 2'b01 || data_count !== 5'd15) begin nerr++; $display("FAIL ovf_pre got rdy=%b cnt=%0d exp 01 15", wr_ready, data_count); end
    wr_valid = 2'b11; wr_data = {32'hBB, 32'hAA}; tick(); idle();
    nvec++; if (data_count !== 5'd16 || full !== 1'b1) begin nerr++; $display("FAIL ovf_count got cnt=%0d full=%b exp 16 1", data_count, full); end
    nvec++; if (ovf_err !== ERR_EN) begin nerr++; $display("FAIL ovf_flag got %b exp %b", ovf_err, ERR_EN); end
    for (int c = 0; c < 7; c++) begin rd_ready = 2'b11; tick(); end
    idle();
    nvec++; if (data_count !== 5'd2 || rd_data[31:0] !== 32'd14 || rd_data[63:32] !== 32'hAA) begin nerr++; $display("FAIL ovf_drain got cnt=%0d %h %h exp 2 e aa", data_count, rd_data[31:0], rd_data[63:32]); end
  endtask

  task automatic test_prefix();
    rst_n = 0; tick(); idle();
    wr_valid = 2'b11; wr_data = {32'd101, 32'd100}; tick();
    wr_data = {32'd103, 32'd102}; tick();
    wr_valid = 2'b01; wr_data = {32'd0, 32'd104}; tick(); idle();
    rd_ready = 2'b10; tick(); idle();
    nvec++; if (data_count !== 5'd5 || rd_data[31:0] !== 32'd100) begin nerr++; $display("FAIL prefix_hold got cnt=%0d d0=%0d exp 5 100", data_count, rd_data[31:0]); end
    rd_ready = 2'b11; tick(); idle();
    nvec++; if (data_count !== 5'd3) begin nerr++; $display("FAIL prefix_pop got cnt=%0d exp 3", data_count); end
    nvec++; if (rd_data[31:0] !== 32'd102 || rd_data[63:32] !== 32'd103) begin nerr++; $display("FAIL prefix_slots got %0d %0d exp 102 103", rd_data[31:0], rd_data[63:32]); end
    nvec++; if (udf_err !== 1'b0) begin nerr++; $display("FAIL prefix_udf got %b exp 0", udf_err); end
  endtask

  task automatic test_random_stream();
    int sz;
    rst_n = 0; tick(); idle();
    for (int c = 0; c < 240; c++) begin
      bit wheavy;
      wheavy = ((c / 40) % 2) == 0;
      wr_valid = wheavy ? 2'($urandom_range(1, 3)) : 2'($urandom_range(0, 3) & $urandom_range(0, 3));
      rd_ready = wheavy ? 2'($urandom_range(0, 3) & $urandom_range(0, 3)) : 2'($urandom_range(1, 3));
      wr_data  = {$urandom, $urandom};
      tick();
      sz = mq.size();
      nvec++; if (data_count !== 5'(sz) || free_count !== 5'(DEPTH - sz)) begin nerr++; $display("FAIL rnd_count cyc %0d got %0d/%0d exp %0d", c, data_count, free_count, sz); end
      nvec++; if (rd_valid !== {sz > 1, sz > 0} || wr_ready !== {DEPTH - sz > 1, DEPTH - sz > 0}) begin nerr++; $display("FAIL rnd_hs cyc %0d got v=%b r=%b sz=%0d", c, rd_valid, wr_ready, sz); end
      for (int k = 0; k < 2; k++)
        if (sz > k) begin
          nvec++; if (rd_data[k*32 +: 32] !== mq[k]) begin nerr++; $display("FAIL rnd_data cyc %0d slot %0d got %h exp %h", c, k, rd_data[k*32 +: 32], mq[k]); end
        end
      nvec++; if (full !== (sz == DEPTH) || empty !== (sz == 0) || almost_full !== (DEPTH - sz <= 2) || almost_empty !== (sz <= 2)) begin nerr++; $display("FAIL rnd_flags cyc %0d got %b%b%b%b sz=%0d", c, full, empty, almost_full, almost_empty, sz); end
      nvec++; if (ovf_err !== m_ovf || udf_err !== m_udf) begin nerr++; $display("FAIL rnd_err cyc %0d got %b%b exp %b%b", c, ovf_err, udf_err, m_ovf, m_udf); end
    end
    idle();
  endtask

  task automatic test_flush();
    rst_n = 0; tick(); idle();
    wr_valid = 2'b11; wr_data = {32'd2, 32'd1}; tick(); tick();
    idle(); rd_ready = 2'b01; wr_valid = 2'b11; flush = 1; tick(); idle();
    nvec++; if (data_count !== 5'd0 || empty !== 1'b1 || rd_valid !== 2'b00) begin nerr++; $display("FAIL flush_count got cnt=%0d e=%b exp 0 1", data_count, empty); end
    rd_ready = 2'b10; tick(); idle();
    nvec++; if (udf_err !== m_udf || udf_err !== ERR_EN) begin nerr++; $display("FAIL flush_udf_set got %b exp %b", udf_err, ERR_EN); end
    wr_valid = 2'b11; wr_data = {32'd4, 32'd3}; tick();
    rd_ready = 2'b11; flush = 1; tick(); idle();
    nvec++; if (data_count !== 5'd0 || empty !== 1'b1) begin nerr++; $display("FAIL flush_both got cnt=%0d e=%b exp 0 1", data_count, empty); end
    nvec++; if (udf_err !== m_udf || ovf_err !== m_ovf) begin nerr++; $display("FAIL flush_err got %b%b exp %b%b", ovf_err, udf_err, m_ovf, m_udf); end
  endtask

  task automatic test_reset_mid();
    wr_valid = 2'b11; wr_data = {32'd6, 32'd5}; tick(); tick();
    rst_n = 0; wr_valid = 2'b11; rd_ready = 2'b11; tick(); idle();
    nvec++; if (data_count !== 5'd0 || wr_ready !== 2'b11 || free_count !== 5'd16) begin nerr++; $display("FAIL rstmid_state got cnt=%0d rdy=%b free=%0d exp 0 11 16", data_count, wr_ready, free_count); end
    nvec++; if (ovf_err !== 1'b0 || udf_err !== 1'b0) begin nerr++; $display("FAIL rstmid_err got %b%b exp 00", ovf_err, udf_err); end
  endtask

  initial begin
    idle();
    test_reset();
    test_fill();
    test_sparse();
    test_overflow();
    test_prefix();
    test_random_stream();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
